// File: rtl/crc_frame_arbiter.sv
// Two-requester byte-frame arbiter that serialises the granted frame into an
// external serial CRC-16 engine and frames the engine's output as a tx stream.
// GAP_CYCLES must be at least 2.
module crc_frame_arbiter #(
    parameter int unsigned MAX_BYTES  = 64,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in0_data,
    input  logic       in0_valid,
    input  logic       in0_last,
    output logic       in0_ready,
    input  logic [7:0] in1_data,
    input  logic       in1_valid,
    input  logic       in1_last,
    output logic       in1_ready,
    output logic       crc_load,
    output logic       crc_finish,
    output logic       crc_bit,
    input  logic       crc_out,
    output logic       tx_bit,
    output logic       tx_valid,
    output logic       tx_last,
    output logic [1:0] grant,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned BcW  = $clog2(MAX_BYTES + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StTail, StGap} state_e;

    state_e           state_q;
    logic [1:0]       grant_q;
    logic             last_served_q;  // 1: requester 1 was served last
    logic [7:0]       shift_q;
    logic             cur_last_q;
    logic [BcW-1:0]   byte_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [3:0]       tail_cnt_q;
    logic [GapW-1:0]  gap_cnt_q;
    logic             tx_valid_q;
    logic             tx_last_q;

    logic       g_valid;
    logic [7:0] g_data;
    logic       g_last;
    logic       at_bit7;
    logic       cap_hit;
    logic       chain;
    logic       take;

    // Granted requester's byte lane and the bit-7 continuation decision
    always_comb begin
        g_valid = grant_q[1] ? in1_valid : in0_valid;
        g_data  = grant_q[1] ? in1_data  : in0_data;
        g_last  = grant_q[1] ? in1_last  : in0_last;
        at_bit7 = (state_q == StShift) && (bit_cnt_q == 3'd7);
        cap_hit = (byte_cnt_q == BcW'(MAX_BYTES));
        // Next byte is fetched on bit 7 so the shift stream has no bubble
        chain   = at_bit7 && !cur_last_q && !cap_hit && g_valid;
        take    = (state_q == StLoad) || chain;
    end

    // Strobes decoded from registered state; handshake needs same-cycle valid
    always_comb begin
        in0_ready  = take && grant_q[0];
        in1_ready  = take && grant_q[1];
        crc_load   = (state_q == StLoad);
        crc_finish = at_bit7 && !chain;
        crc_bit    = (state_q == StShift) && shift_q[7];
        underrun   = at_bit7 && !cur_last_q && !cap_hit && !g_valid;
        busy       = (state_q != StIdle);
        grant      = grant_q;
        tx_bit     = crc_out;
        tx_valid   = tx_valid_q;
        tx_last    = tx_last_q;
    end

    // Frame sequencer: arbitration, byte shifting, CRC tail and inter-frame gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
            shift_q       <= 8'h00;
            cur_last_q    <= 1'b0;
            byte_cnt_q    <= '0;
            bit_cnt_q     <= 3'd0;
            tail_cnt_q    <= 4'd0;
            gap_cnt_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
        end else begin
            // Engine output lags its input by one register stage
            tx_valid_q <= (state_q == StShift) || (state_q == StTail);
            tx_last_q  <= (state_q == StTail) && (tail_cnt_q == 4'd15);
            unique case (state_q)
                StIdle: begin
                    if (in0_valid || in1_valid) begin
                        if (in0_valid && in1_valid) begin
                            grant_q <= last_served_q ? 2'b01 : 2'b10;
                        end else begin
                            grant_q <= in0_valid ? 2'b01 : 2'b10;
                        end
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    shift_q    <= g_data;
                    cur_last_q <= g_last;
                    byte_cnt_q <= BcW'(1);
                    bit_cnt_q  <= 3'd0;
                    state_q    <= StShift;
                end
                StShift: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (chain) begin
                        shift_q    <= g_data;
                        cur_last_q <= g_last;
                        byte_cnt_q <= byte_cnt_q + BcW'(1);
                    end else begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        if (at_bit7) begin
                            tail_cnt_q <= 4'd0;
                            state_q    <= StTail;
                        end
                    end
                end
                StTail: begin
                    tail_cnt_q <= tail_cnt_q + 4'd1;
                    if (tail_cnt_q == 4'd15) begin
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    gap_cnt_q <= gap_cnt_q + GapW'(1);
                    if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                        last_served_q <= grant_q[1];
                        grant_q       <= 2'b00;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Scoreboard bench: a frame-level reference model predicts every tx frame,
// a monitor collects the serial stream and compares. A small serial CRC-16
// engine (poly 0x1021, init 0) closes the loop on crc_out.
module tb_crc_frame_arbiter;

    localparam int unsigned MAXB = 2;
    localparam int unsigned GAP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in0_data, in1_data;
    logic       in0_valid, in1_valid, in0_last, in1_last;
    logic       in0_ready, in1_ready;
    logic       crc_load, crc_finish, crc_bit, crc_out;
    logic       tx_bit, tx_valid, tx_last, busy, underrun;
    logic [1:0] grant;

    always #5 clk = ~clk;

    crc_frame_arbiter #(
        .MAX_BYTES (MAXB),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .crc_load  (crc_load),
        .crc_finish(crc_finish),
        .crc_bit   (crc_bit),
        .crc_out   (crc_out),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .grant     (grant),
        .busy      (busy),
        .underrun  (underrun)
    );

    // Serial CRC engine: passes data through while accumulating, then shifts CRC out
    logic [15:0] eng_crc;
    logic        eng_tail;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_crc  <= 16'h0;
            eng_tail <= 1'b0;
            crc_out  <= 1'b0;
        end else if (crc_load) begin
            eng_crc  <= 16'h0;
            eng_tail <= 1'b0;
            crc_out  <= 1'b0;
        end else if (!eng_tail) begin
            crc_out <= crc_bit;
            eng_crc <= {eng_crc[14:0], 1'b0} ^ ((eng_crc[15] ^ crc_bit) ? 16'h1021 : 16'h0);
            if (crc_finish) eng_tail <= 1'b1;
        end else begin
            crc_out <= eng_crc[15];
            eng_crc <= {eng_crc[14:0], 1'b0};
        end
    end

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct {
        logic [1:0]  grant;
        logic [63:0] bits;
        int          len;
        logic        und;
    } frame_t;

    byte_t       q0[$], q1[$];
    byte_t       rs0[$], rs1[$];
    frame_t      exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          m_last = 1;
    logic [63:0] last_bits = '0;
    int          last_len = 0;
    logic [7:0]  tr[48];
    logic [7:0]  ref_tr[48];

    function automatic byte_t mk(input logic [7:0] d, input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'h0;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Reference model: frames come from the byte streams by round-robin ownership,
    // ending at a last byte, at MAXB bytes, or (underrun) when the stream runs dry
    task automatic issue(input byte_t s0[$], input byte_t s1[$]);
        byte_t a0[$];
        byte_t a1[$];
        a0 = s0;
        a1 = s1;
        while (a0.size() > 0 || a1.size() > 0) begin
            int          r;
            int          cnt;
            frame_t      f;
            byte_t       b;
            logic [7:0]  fb[$];
            logic [15:0] c;
            if (a0.size() > 0 && a1.size() > 0) r = (m_last == 0) ? 1 : 0;
            else r = (a0.size() > 0) ? 0 : 1;
            f.grant = (r == 0) ? 2'b01 : 2'b10;
            f.bits = '0;
            f.und = 1'b0;
            cnt = 0;
            forever begin
                if (r == 0) b = a0.pop_front();
                else b = a1.pop_front();
                fb.push_back(b.data);
                cnt++;
                if (b.last || cnt == int'(MAXB)) break;
                if ((r == 0 ? a0.size() : a1.size()) == 0) begin
                    f.und = 1'b1;
                    break;
                end
            end
            c = crc16(fb);
            foreach (fb[i]) f.bits = {f.bits[55:0], fb[i]};
            f.bits = {f.bits[47:0], c};
            f.len = 8 * cnt + 16;
            exp_q.push_back(f);
            m_last = r;
        end
        foreach (s0[i]) q0.push_back(s0[i]);
        foreach (s1[i]) q1.push_back(s1[i]);
    endtask

    // Requester drivers: hold a byte valid until accepted, then present the next
    initial begin : driver
        logic acc0, acc1;
        in0_valid = 1'b0; in0_data = 8'h0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = 8'h0; in1_last = 1'b0;
        forever begin
            @(negedge clk);
            acc0 = in0_valid && in0_ready;
            acc1 = in1_valid && in1_ready;
            @(posedge clk);
            #1;
            if (acc0) void'(q0.pop_front());
            if (acc1) void'(q1.pop_front());
            if (q0.size() > 0) begin
                in0_valid = 1'b1; in0_data = q0[0].data; in0_last = q0[0].last;
            end else begin
                in0_valid = 1'b0; in0_data = 8'h0; in0_last = 1'b0;
            end
            if (q1.size() > 0) begin
                in1_valid = 1'b1; in1_data = q1[0].data; in1_last = q1[0].last;
            end else begin
                in1_valid = 1'b0; in1_data = 8'h0; in1_last = 1'b0;
            end
        end
    end

    // Monitor: assemble tx frames and compare against the model's queue
    initial begin : monitor
        logic [63:0] acc;
        int          n;
        logic [1:0]  g;
        logic        und_seen;
        logic        in_fr;
        frame_t      f;
        acc = '0; n = 0; g = 2'b00; und_seen = 1'b0; in_fr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc = '0; n = 0; und_seen = 1'b0; in_fr = 1'b0;
            end else begin
                if (in0_ready || in1_ready) check("ready_both", 64'(in0_ready & in1_ready), 64'd0);
                if (underrun) begin
                    und_seen = 1'b1;
                    check("underrun_with_finish", 64'(crc_finish), 64'd1);
                end
                if (tx_valid) begin
                    if (!in_fr) begin
                        in_fr = 1'b1;
                        g = grant;
                    end
                    acc = {acc[62:0], tx_bit};
                    n++;
                    if (tx_last) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", 64'd1, 64'd0);
                        end else begin
                            f = exp_q.pop_front();
                            check("frame_len", 64'(n), 64'(f.len));
                            check("frame_bits", acc, f.bits);
                            check("frame_grant", 64'(g), 64'(f.grant));
                            check("frame_underrun", 64'(und_seen), 64'(f.und));
                        end
                        last_bits = acc;
                        last_len = n;
                        acc = '0; n = 0; und_seen = 1'b0; in_fr = 1'b0;
                    end
                end else begin
                    if (in_fr) begin
                        check("tx_contiguous", 64'd0, 64'd1);
                        acc = '0; n = 0; in_fr = 1'b0;
                    end
                    if (tx_last) check("tx_last_without_valid", 64'd1, 64'd0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in0_ready"}, 64'(in0_ready), 64'd0);
        check({tag, "_in1_ready"}, 64'(in1_ready), 64'd0);
        check({tag, "_crc_load"}, 64'(crc_load), 64'd0);
        check({tag, "_crc_finish"}, 64'(crc_finish), 64'd0);
        check({tag, "_crc_bit"}, 64'(crc_bit), 64'd0);
        check({tag, "_tx_bit"}, 64'(tx_bit), 64'd0);
        check({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, "_tx_last"}, 64'(tx_last), 64'd0);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_underrun"}, 64'(underrun), 64'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, 64'(c >= budget), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Record per-cycle strobes: {grant, load, crc_bit, finish, tx_valid, tx_last, tx_bit}
    task automatic capture(input string tag, output int l);
        l = -1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            tr[i] = {grant, crc_load, crc_bit, crc_finish, tx_valid, tx_last, tx_bit};
            if (l < 0 && crc_load) l = i;
        end
        if (l < 0 || l > 20) begin
            check({tag, "_load_seen"}, 64'd0, 64'd1);
            l = 0;
        end
    endtask

    // Single 0x80 last-byte frame waveform
    task automatic check_single_80(input string tag, input int l);
        int         loads, fins, fin_pos, tvs, tv_first, tls, tl_pos;
        logic [7:0] bits;
        loads = 0; fins = 0; fin_pos = -1; tvs = 0; tv_first = -1; tls = 0; tl_pos = -1;
        bits = 8'h0;
        for (int i = 0; i < 48; i++) begin
            loads += int'(tr[i][5]);
            if (tr[i][3]) begin fins++; if (fin_pos < 0) fin_pos = i; end
            if (tr[i][2]) begin tvs++; if (tv_first < 0) tv_first = i; end
            if (tr[i][1]) begin tls++; if (tl_pos < 0) tl_pos = i; end
        end
        for (int k = 1; k <= 8; k++) bits = {bits[6:0], tr[l + k][4]};
        check({tag, "_load_count"}, 64'(loads), 64'd1);
        check({tag, "_crc_bits"}, 64'(bits), 64'h80);
        check({tag, "_finish_count"}, 64'(fins), 64'd1);
        check({tag, "_finish_pos"}, 64'(fin_pos), 64'(l + 8));
        check({tag, "_txv_count"}, 64'(tvs), 64'd24);
        check({tag, "_txv_first"}, 64'(tv_first), 64'(l + 2));
        check({tag, "_txlast_count"}, 64'(tls), 64'd1);
        check({tag, "_txlast_pos"}, 64'(tl_pos), 64'(l + 25));
        check({tag, "_grant"}, 64'(tr[l][7:6]), 64'h1);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1);
    end

    initial begin : main
        int l1, l2, nr, c, mism;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous requests after reset, twice: in0, in1, then in0, in1
        rs0.delete(); rs1.delete();
        rs0.push_back(mk(8'h11, 1'b1));
        rs1.push_back(mk(8'h22, 1'b1));
        issue(rs0, rs1);
        wait_idle("rr1", 2000);
        issue(rs0, rs1);
        wait_idle("rr2", 2000);

        // 0x80 single-byte frame waveform
        rs0.delete(); rs1.delete();
        rs0.push_back(mk(8'h80, 1'b1));
        issue(rs0, rs1);
        capture("f80", l1);
        check_single_80("f80", l1);
        for (int i = 0; i < 48; i++) ref_tr[i] = tr[i];
        wait_idle("f80", 2000);

        // All-zero frame
        rs0.delete();
        rs0.push_back(mk(8'h00, 1'b1));
        issue(rs0, rs1);
        wait_idle("zero", 2000);
        check("zero_frame_bits", last_bits, 64'd0);
        check("zero_frame_len", 64'(last_len), 64'd24);

        // Underrun: non-last byte then valid dropped
        rs0.delete();
        rs0.push_back(mk(8'hA5, 1'b0));
        issue(rs0, rs1);
        wait_idle("underrun", 2000);

        // MAXB cut: three non-last bytes from in1
        rs0.delete(); rs1.delete();
        rs1.push_back(mk(8'h01, 1'b0));
        rs1.push_back(mk(8'h02, 1'b0));
        rs1.push_back(mk(8'h03, 1'b0));
        issue(rs0, rs1);
        wait_idle("maxcut", 2000);

        // Reset during the second byte's shift drops the frame
        q0.push_back(mk(8'h12, 1'b0));
        q0.push_back(mk(8'h34, 1'b1));
        nr = 0; c = 0;
        while (nr < 2 && c < 200) begin
            @(negedge clk);
            if (in0_ready) nr++;
            c++;
        end
        check("rst_mid_bytes_taken", 64'(nr), 64'd2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("rst_mid");
        repeat (3) @(negedge clk);
        m_last = 1;
        rst = 1'b1;
        @(negedge clk);
        rs0.delete(); rs1.delete();
        rs0.push_back(mk(8'h80, 1'b1));
        issue(rs0, rs1);
        capture("post_rst", l2);
        check_single_80("post_rst", l2);
        mism = 0;
        for (int k = 0; k < 28; k++) if (tr[l2 + k] !== ref_tr[l1 + k]) mism++;
        check("post_rst_repro_mismatches", 64'(mism), 64'd0);
        wait_idle("post_rst", 2000);

        // Randomised streams on both requesters
        for (int it = 0; it < 25; it++) begin
            int n0, n1;
            rs0.delete(); rs1.delete();
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(0, 5);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++)
                rs0.push_back(mk(8'($urandom), $urandom_range(0, 2) == 0));
            for (int i = 0; i < n1; i++)
                rs1.push_back(mk(8'($urandom), $urandom_range(0, 2) == 0));
            issue(rs0, rs1);
            wait_idle("rand", 3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
